sine_dds_offset_binary: RTL

- Direct digital synthesis (DDS) sine source for the DAC output chain.
- Produces one 14-bit offset-binary sample per clock from a 32-bit phase accumulator and a quarter-wave sine LUT.
- Feeds the offset-binary-to-two's-complement converter that drives the Zmod DAC 1411.
- Frequency tuning word (FTW) changes take effect only at phase wrap, so the output waveform is never discontinuous.

---
 rtl/sine_dds_offset_binary.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sine_dds_offset_binary.sv
// Quarter-wave DDS sine source: 32-bit phase accumulator feeding a 3-stage LUT pipeline,
// producing offset-binary samples; FTW updates are deferred to a phase wrap.
module sine_dds_offset_binary #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8,
   parameter int OUT_W   = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [PHASE_W-1:0] ftw_in,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   input  logic [PHASE_W-1:0] phase_off,
   output logic [OUT_W-1:0]   sample_out,
   output logic               sample_valid,
   output logic               busy
);

   localparam int               MAG_W    = OUT_W - 1;
   localparam int               LUT_N    = 1 << LUT_AW;
   localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {MAG_W{1'b0}}};
   localparam real              MAG_MAX  = real'((1 << MAG_W) - 1);
   localparam real              HALF_PI  = 1.5707963267948966;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOP
   } state_t;

   state_t             r_state;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_ftw_active;
   logic [PHASE_W-1:0] r_ftw_pend;
   logic               r_pend_flag;
   logic               r_ftw_ready;
   logic               r_busy;

   logic               r_s1_vld;
   logic               r_s1_neg;
   logic [LUT_AW-1:0]  r_s1_addr;
   logic               r_s2_vld;
   logic               r_s2_neg;
   logic [MAG_W-1:0]   r_s2_mag;
   logic [OUT_W-1:0]   r_sample;
   logic               r_sample_vld;

   logic [PHASE_W:0]   w_sum;
   logic               w_wrap;
   logic               w_accept;
   logic               w_apply;
   logic [LUT_AW+1:0]  w_p_top;
   logic [LUT_AW-1:0]  w_addr;
   logic [MAG_W-1:0]   w_lut [LUT_N];

   // Midpoint-sampled quarter sine, folded to constants at elaboration
   for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      localparam real ANG = HALF_PI * (real'(gi) + 0.5) / real'(LUT_N);
      localparam int  VAL = $rtoi(MAG_MAX * $sin(ANG) + 0.5);
      assign w_lut[gi] = MAG_W'(VAL);
   end

   assign w_sum    = {1'b0, r_phase} + {1'b0, r_ftw_active};
   assign w_wrap   = w_sum[PHASE_W];
   assign w_accept = ftw_valid & ~r_pend_flag;
   assign w_apply  = r_pend_flag & ((r_state == ST_IDLE) | w_wrap);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_phase      <= '0;
         r_ftw_active <= '0;
         r_ftw_pend   <= '0;
         r_pend_flag  <= 1'b0;
         r_ftw_ready  <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         // A word accepted on a wrap cycle only lands in pend; it waits for the next wrap
         if (w_apply) begin
            r_ftw_active <= r_ftw_pend;
            r_pend_flag  <= 1'b0;
            r_ftw_ready  <= 1'b1;
         end
         if (w_accept) begin
            r_ftw_pend  <= ftw_in;
            r_pend_flag <= 1'b1;
            r_ftw_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               r_phase <= '0;
               if (enable) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               r_phase <= w_sum[PHASE_W-1:0];
               if (!enable) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (enable) begin
                  r_state <= ST_RUN;
                  r_phase <= w_sum[PHASE_W-1:0];
               end else if (w_wrap || (r_ftw_active == '0)) begin
                  r_state <= ST_IDLE;
                  r_phase <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_phase <= w_sum[PHASE_W-1:0];
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_phase <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Only quadrant and LUT index bits of the offset phase are needed
   assign w_p_top = (LUT_AW+2)'((r_phase + phase_off) >> (PHASE_W - LUT_AW - 2));
   assign w_addr  = w_p_top[LUT_AW-1:0] ^ {LUT_AW{w_p_top[LUT_AW]}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_vld     <= 1'b0;
         r_s1_neg     <= 1'b0;
         r_s1_addr    <= '0;
         r_s2_vld     <= 1'b0;
         r_s2_neg     <= 1'b0;
         r_s2_mag     <= '0;
         r_sample     <= MIDSCALE;
         r_sample_vld <= 1'b0;
      end else begin
         r_s1_vld  <= (r_state != ST_IDLE);
         r_s1_neg  <= w_p_top[LUT_AW+1];
         r_s1_addr <= w_addr;

         r_s2_vld  <= r_s1_vld;
         r_s2_neg  <= r_s1_neg;
         r_s2_mag  <= w_lut[r_s1_addr];

         r_sample_vld <= r_s2_vld;
         if (!r_s2_vld) begin
            r_sample <= MIDSCALE;
         end else if (r_s2_neg) begin
            r_sample <= MIDSCALE - {1'b0, r_s2_mag};
         end else begin
            r_sample <= MIDSCALE + {1'b0, r_s2_mag};
         end
      end
   end

   assign ftw_ready    = r_ftw_ready;
   assign busy         = r_busy;
   assign sample_out   = r_sample;
   assign sample_valid = r_sample_vld;

endmodule
